mmm_ctrl: RTL and testbench
===========================

MMM_CTRL -- requirements
Module: mmm_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  M  7  rows of A and of the output matrix
  N  9  columns of B and of the output matrix; also output FIFO depth
  MAXK  8  maximum inner dimension
  MAC_LAT  2  cycles from the last valid_input of an element to its result at mac out
  K_BITS  $clog2(MAXK+1)  width of K (localparam)
  AW_A  $clog2(M*MAXK)  A address width (localparam)
  AW_B  $clog2(MAXK*N)  B address width (localparam)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock, all logic rising-edge
  reset  in  1  asynchronous, active-low reset
  matrices_loaded  in  1  level; A and B valid in input memories
  K  in  K_BITS  inner dimension, valid while matrices_loaded=1
  capacity  in  $clog2(N+1)  free entries in the output FIFO
  A_read_addr  out  AW_A  A memory read address
  B_read_addr  out  AW_B  B memory read address
  valid_input  out  1  MAC operand-valid strobe
  clear_acc  out  1  MAC accumulator restart strobe
  wr_en  out  1  output FIFO write strobe; data path is mac out -> fifo data_in, outside this block
  compute_finished  out  1  one-cycle pulse at the end of the product
  busy  out  1  high in every state except IDLE

Function
REQ-003 States SHALL be IDLE, WAIT_CAP, COMPUTE, DRAIN, DONE.
REQ-004 In IDLE with matrices_loaded=1: latch K, set i=0, j=0, k=0, and go to WAIT_CAP. If the latched K=0, go to DONE instead, with no MAC and no FIFO activity.
REQ-005 WAIT_CAP SHALL go to COMPUTE when capacity==N (FIFO empty). Otherwise it holds, with no limit on stall length.
REQ-006 Each COMPUTE cycle SHALL issue one operand pair:
  - A_read_addr = i*K+k
  - B_read_addr = k*N+j
  - registered outputs, valid in the cycle after the state/counter update.
REQ-007 The counters SHALL advance as follows:
  - k increments every COMPUTE cycle.
  - At k=K-1: k returns to 0 and j increments.
  - At j=N-1 with k=K-1: j returns to 0, i increments, and the FSM goes to DRAIN.
  - There are no bubbles between elements of a row.
REQ-008 Strobe timing SHALL be:
  - valid_input is asserted exactly 1 cycle after each issued address (read latency 1).
  - clear_acc is asserted together with valid_input on the k=0 operand of each element.
REQ-009 A "last" flag tagged on the k=K-1 operand SHALL travel with valid_input through a MAC_LAT-stage shift register. wr_en is the output of that register, so wr_en rises 1+MAC_LAT cycles after the k=K-1 address issue. Exactly one write occurs per output element.
REQ-010 DRAIN SHALL wait until the delay line holds no pending "last" flag. It then goes to WAIT_CAP if i<M, else to DONE.
REQ-011 DONE SHALL assert compute_finished for exactly one cycle, then go to IDLE. matrices_loaded is not sampled in DONE.
REQ-012 Total FIFO writes per product SHALL be exactly M*N, in row-major order (i outer, j inner).
REQ-013 K SHALL be sampled only in IDLE. Changes to K during a product are ignored.
REQ-014 Address arithmetic SHALL use unsigned values at full AW_A/AW_B width, with no wrap for in-range K (1..MAXK).
REQ-015 Outputs not described as active above (valid_input, clear_acc, wr_en, compute_finished) SHALL be 0. The address outputs hold their last value.

Reset
REQ-016 While reset=0, asynchronously and independently of clk:
  - the state is IDLE
  - i, j, k, the latched K and the delay line are 0
  - every output is 0
REQ-017 Reset deasserted mid-COMPUTE or mid-DRAIN SHALL discard all in-flight flags. No wr_en or compute_finished is produced for the aborted product.

Verification
REQ-018 A bench SHALL cover, at minimum:
  - M=7, N=9, K=8, FIFO always empty -> 63 wr_en pulses in row-major order, 504 valid_input strobes, 63 clear_acc strobes, exactly one compute_finished.
  - K=1 -> clear_acc=valid_input on every operand; wr_en rises 3 cycles (MAC_LAT=2) after each address issue; addresses A=i, B=j.
  - capacity held at 5 after row 0 -> controller stalls in WAIT_CAP with no valid_input; capacity returns to 9 -> row 1 starts the next cycle.
  - K=0 with matrices_loaded=1 -> compute_finished pulses within 3 cycles; zero wr_en and zero valid_input.
  - reset pulsed low at cycle 20 of COMPUTE -> all outputs 0 immediately; no wr_en after release; a new product then completes correctly with 63 writes.
  - K changed from 8 to 3 mid-product -> addresses and counts still follow K=8.

Source files
------------

// File: rtl/mmm_ctrl.sv
// Matrix-multiply sequencer: walks i/j/k over A (MxK) and B (KxN), drives the MAC strobes
// and writes one output element per (i,j) into the output FIFO, one row per FIFO fill.
module mmm_ctrl #(
    parameter int unsigned M       = 7,
    parameter int unsigned N       = 9,
    parameter int unsigned MAXK    = 8,
    parameter int unsigned MAC_LAT = 2,
    localparam int unsigned K_BITS = $clog2(MAXK + 1),
    localparam int unsigned AW_A   = $clog2(M * MAXK),
    localparam int unsigned AW_B   = $clog2(MAXK * N),
    localparam int unsigned CW     = $clog2(N + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              matrices_loaded,
    input  logic [K_BITS-1:0] K,
    input  logic [CW-1:0]     capacity,
    output logic [AW_A-1:0]   A_read_addr,
    output logic [AW_B-1:0]   B_read_addr,
    output logic              valid_input,
    output logic              clear_acc,
    output logic              wr_en,
    output logic              compute_finished,
    output logic              busy
);

    localparam int unsigned IW = $clog2(M + 1);
    localparam int unsigned JW = $clog2(N + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_CAP = 3'd1;
    localparam logic [2:0] S_COMPUTE  = 3'd2;
    localparam logic [2:0] S_DRAIN    = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]         state, state_nxt;
    logic [IW-1:0]      i, i_nxt;
    logic [JW-1:0]      j, j_nxt;
    logic [K_BITS-1:0]  k, k_nxt;
    logic [K_BITS-1:0]  k_lat, k_lat_nxt;

    logic               issue_c, first_c, last_c, finish_c, pending_c;
    logic [AW_A-1:0]    a_addr_c;
    logic [AW_B-1:0]    b_addr_c;

    // Operand tags aligned with the address, then with valid_input, then the MAC delay line
    logic               issue_q, first_q, last_q;
    logic               last_v;
    logic [MAC_LAT-1:0] last_dl;

    assign pending_c = (issue_q & last_q) | last_v | (|last_dl);
    assign a_addr_c  = AW_A'(i) * AW_A'(k_lat) + AW_A'(k);
    assign b_addr_c  = AW_B'(k) * AW_B'(N) + AW_B'(j);

    // State and loop counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            k_lat <= '0;
        end else begin
            state <= state_nxt;
            i     <= i_nxt;
            j     <= j_nxt;
            k     <= k_nxt;
            k_lat <= k_lat_nxt;
        end
    end

    // Next-state, counter stepping and per-cycle operand tags
    always_comb begin
        state_nxt = state;
        i_nxt     = i;
        j_nxt     = j;
        k_nxt     = k;
        k_lat_nxt = k_lat;
        issue_c   = 1'b0;
        first_c   = 1'b0;
        last_c    = 1'b0;
        finish_c  = 1'b0;
        case (state)
            S_IDLE: begin
                if (matrices_loaded) begin
                    k_lat_nxt = K;
                    i_nxt     = '0;
                    j_nxt     = '0;
                    k_nxt     = '0;
                    state_nxt = (K == '0) ? S_DONE : S_WAIT_CAP;
                end
            end
            S_WAIT_CAP: begin
                if (capacity == CW'(N)) state_nxt = S_COMPUTE;
            end
            S_COMPUTE: begin
                issue_c = 1'b1;
                first_c = (k == '0);
                last_c  = (k == k_lat - K_BITS'(1));
                if (last_c) begin
                    k_nxt = '0;
                    if (j == JW'(N - 1)) begin
                        j_nxt     = '0;
                        i_nxt     = i + IW'(1);
                        state_nxt = S_DRAIN;
                    end else begin
                        j_nxt = j + JW'(1);
                    end
                end else begin
                    k_nxt = k + K_BITS'(1);
                end
            end
            S_DRAIN: begin
                if (!pending_c) state_nxt = (i < IW'(M)) ? S_WAIT_CAP : S_DONE;
            end
            S_DONE: begin
                finish_c  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs and the MAC-latency "last" delay line
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            A_read_addr      <= '0;
            B_read_addr      <= '0;
            issue_q          <= 1'b0;
            first_q          <= 1'b0;
            last_q           <= 1'b0;
            valid_input      <= 1'b0;
            clear_acc        <= 1'b0;
            last_v           <= 1'b0;
            last_dl          <= '0;
            compute_finished <= 1'b0;
            busy             <= 1'b0;
        end else begin
            if (issue_c) begin
                A_read_addr <= a_addr_c;
                B_read_addr <= b_addr_c;
            end
            issue_q          <= issue_c;
            first_q          <= first_c;
            last_q           <= last_c;
            valid_input      <= issue_q;
            clear_acc        <= issue_q & first_q;
            last_v           <= issue_q & last_q;
            last_dl          <= (last_dl << 1) | MAC_LAT'(last_v);
            compute_finished <= finish_c;
            busy             <= (state_nxt != S_IDLE);
        end
    end

    assign wr_en = last_dl[MAC_LAT-1];

endmodule

// File: tb/tb_mmm_ctrl.sv
// Self-checking bench for mmm_ctrl: observed operand/write streams are compared against
// sequences generated from the matrix-product loop nest.
module tb_mmm_ctrl;

    localparam int M       = 7;
    localparam int N       = 9;
    localparam int MAXK    = 8;
    localparam int MAC_LAT = 2;
    localparam int K_BITS  = $clog2(MAXK + 1);
    localparam int AW_A    = $clog2(M * MAXK);
    localparam int AW_B    = $clog2(MAXK * N);
    localparam int CW      = $clog2(N + 1);

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              matrices_loaded = 1'b0;
    logic [K_BITS-1:0] K = '0;
    logic [CW-1:0]     capacity = CW'(N);
    logic [AW_A-1:0]   A_read_addr;
    logic [AW_B-1:0]   B_read_addr;
    logic              valid_input, clear_acc, wr_en, compute_finished, busy;

    mmm_ctrl #(.M(M), .N(N), .MAXK(MAXK), .MAC_LAT(MAC_LAT)) dut (
        .clk              (clk),
        .reset            (reset),
        .matrices_loaded  (matrices_loaded),
        .K                (K),
        .capacity         (capacity),
        .A_read_addr      (A_read_addr),
        .B_read_addr      (B_read_addr),
        .valid_input      (valid_input),
        .clear_acc        (clear_acc),
        .wr_en            (wr_en),
        .compute_finished (compute_finished),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations from the last product run
    int obs_a[$], obs_b[$], obs_clr[$], vcyc[$], wcyc[$];
    int cf_cnt, cf_cyc, stall_valid, restart_lat;
    bit timed_out;

    function automatic logic [AW_A+AW_B+4:0] out_vec();
        return {A_read_addr, B_read_addr, valid_input, clear_acc, wr_en, compute_finished, busy};
    endfunction

    // Launch one product and record every strobe until a few cycles past compute_finished
    task automatic run(input int kk, input int kchg_at, input int stall_len, input int stall_cap);
        int cyc = 0, prev_a = 0, prev_b = 0, wr_n = 0, stall_left = 0, since_restore = -1, tail = 0;
        bit done = 0;
        obs_a.delete(); obs_b.delete(); obs_clr.delete(); vcyc.delete(); wcyc.delete();
        cf_cnt = 0; cf_cyc = -1; stall_valid = 0; restart_lat = -1; timed_out = 0;
        K = K_BITS'(kk);
        capacity = CW'(N);
        matrices_loaded = 1'b1;
        while (tail < 6) begin
            @(posedge clk); #1;
            cyc++;
            if (since_restore >= 0) since_restore++;
            if (valid_input) begin
                obs_a.push_back(prev_a);
                obs_b.push_back(prev_b);
                obs_clr.push_back(int'(clear_acc));
                vcyc.push_back(cyc);
                if (stall_left > 0) stall_valid++;
                if (since_restore >= 0 && restart_lat < 0) restart_lat = since_restore;
            end
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) begin
                    capacity = CW'(N);
                    since_restore = 0;
                end
            end
            if (wr_en) begin
                wcyc.push_back(cyc);
                wr_n++;
                if (wr_n == N && stall_len > 0) begin
                    capacity = CW'(stall_cap);
                    stall_left = stall_len;
                end
            end
            if (compute_finished) begin
                cf_cnt++;
                if (cf_cyc < 0) cf_cyc = cyc;
                matrices_loaded = 1'b0;
                done = 1'b1;
            end
            if (done) tail++;
            if (kchg_at > 0 && cyc == kchg_at) K = K_BITS'(3);
            prev_a = int'(A_read_addr);
            prev_b = int'(B_read_addr);
            if (cyc > 5000) begin
                timed_out = 1'b1;
                break;
            end
        end
        matrices_loaded = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, want 0", out_vec());
        end
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_vec() !== '0) begin
            n_fail++;
            $display("FAIL idle_outputs: got %h, want 0", out_vec());
        end
    endtask

    // Full product with inner dimension kk; every operand and write compared with the loop nest
    task automatic test_product(input string name, input int kk, input int kchg_at);
        int idx = 0, nv = M * N * kk, clr_n = 0;
        run(kk, kchg_at, 0, 0);
        n_checks++;
        if (timed_out) begin
            n_fail++;
            $display("FAIL %s_timeout: no compute_finished within 5000 cycles", name);
        end
        n_checks++;
        if (obs_a.size() != nv) begin
            n_fail++;
            $display("FAIL %s_valid_count: got %0d, want %0d", name, obs_a.size(), nv);
        end
        n_checks++;
        if (wcyc.size() != M * N) begin
            n_fail++;
            $display("FAIL %s_write_count: got %0d, want %0d", name, wcyc.size(), M * N);
        end
        n_checks++;
        if (cf_cnt != 1) begin
            n_fail++;
            $display("FAIL %s_finish_count: got %0d, want 1", name, cf_cnt);
        end
        foreach (obs_clr[q]) clr_n += obs_clr[q];
        n_checks++;
        if (clr_n != M * N) begin
            n_fail++;
            $display("FAIL %s_clear_count: got %0d, want %0d", name, clr_n, M * N);
        end
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                for (int k = 0; k < kk; k++) begin
                    if (idx < obs_a.size()) begin
                        int ea = i * kk + k;
                        int eb = k * N + j;
                        int ec = (k == 0) ? 1 : 0;
                        bit contig = (j == 0 && k == 0) || (vcyc[idx] == vcyc[idx-1] + 1);
                        n_checks++;
                        if (obs_a[idx] != ea || obs_b[idx] != eb || obs_clr[idx] != ec || !contig) begin
                            n_fail++;
                            $display("FAIL %s_operand[%0d,%0d,%0d]: got A=%0d B=%0d clr=%0d contiguous=%0d, want A=%0d B=%0d clr=%0d contiguous=1",
                                     name, i, j, k, obs_a[idx], obs_b[idx], obs_clr[idx], contig, ea, eb, ec);
                        end
                    end
                    idx++;
                end
                if ((i * N + j) < wcyc.size() && idx - 1 < vcyc.size()) begin
                    n_checks++;
                    if (wcyc[i * N + j] != vcyc[idx - 1] + MAC_LAT) begin
                        n_fail++;
                        $display("FAIL %s_write_time[%0d,%0d]: got cycle %0d, want %0d",
                                 name, i, j, wcyc[i * N + j], vcyc[idx - 1] + MAC_LAT);
                    end
                end
            end
        end
    endtask

    task automatic test_k0();
        run(0, 0, 0, 0);
        n_checks++;
        if (cf_cnt != 1 || cf_cyc < 1 || cf_cyc > 3) begin
            n_fail++;
            $display("FAIL k0_finish: got count=%0d at cycle %0d, want 1 within 3 cycles", cf_cnt, cf_cyc);
        end
        n_checks++;
        if (obs_a.size() != 0 || wcyc.size() != 0) begin
            n_fail++;
            $display("FAIL k0_activity: got valid=%0d writes=%0d, want 0 0", obs_a.size(), wcyc.size());
        end
    endtask

    task automatic test_capacity_stall(input string name, input int cap, input int len);
        run(MAXK, 0, len, cap);
        n_checks++;
        if (stall_valid != 0) begin
            n_fail++;
            $display("FAIL %s_stall_valid: got %0d strobes while stalled, want 0", name, stall_valid);
        end
        n_checks++;
        if (restart_lat != 3) begin
            n_fail++;
            $display("FAIL %s_restart_latency: got %0d, want 3", name, restart_lat);
        end
        n_checks++;
        if (wcyc.size() != M * N || cf_cnt != 1 || timed_out) begin
            n_fail++;
            $display("FAIL %s_completion: got writes=%0d finish=%0d timeout=%0d, want %0d 1 0",
                     name, wcyc.size(), cf_cnt, timed_out, M * N);
        end
    endtask

    task automatic test_reset_mid();
        int nv = 0, cyc = 0, bad = 0;
        K = K_BITS'(MAXK);
        capacity = CW'(N);
        matrices_loaded = 1'b1;
        while (nv < 20 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (valid_input) nv++;
        end
        n_checks++;
        if (nv < 20) begin
            n_fail++;
            $display("FAIL reset_mid_start: got %0d strobes, want 20", nv);
        end
        #2;
        reset = 1'b0;
        matrices_loaded = 1'b0;
        #1;
        n_checks++;
        if (out_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %h, want 0", out_vec());
        end
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
            if (wr_en || compute_finished || valid_input || busy) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_mid_aftermath: got %0d active cycles, want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_product("k8", MAXK, 0);
        test_product("k1", 1, 0);
        test_k0();
        test_capacity_stall("cap5", 5, $urandom_range(4, 30));
        test_capacity_stall("cap_rand", $urandom_range(0, N - 1), $urandom_range(2, 40));
        test_reset_mid();
        test_product("after_reset", MAXK, 0);
        test_product("k_change", MAXK, 60);
        repeat (2) test_product("rand_k", $urandom_range(1, MAXK), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
